// File: rtl/md5_round_ctl_pkg.sv
// ---------------------------------------------------------------------------
// md5_round_ctl_pkg
// Shared constants and types for the MD5 round sequencer.
//   WORD_COUNT  : message words per 512-bit block (16)
//   ROUND_COUNT : MD5 rounds per block (64)
//   LAST_WORD   : load counter value of the final word of a block
//   LAST_ROUND  : round index of the final round
//   state_t     : sequencer state encoding (LOAD = 0, RUN = 1, DONE = 2)
// ---------------------------------------------------------------------------
package md5_round_ctl_pkg;

    localparam int WORD_COUNT  = 16;
    localparam int ROUND_COUNT = 64;

    localparam logic [3:0] LAST_WORD  = 4'(WORD_COUNT - 1);
    localparam logic [5:0] LAST_ROUND = 6'(ROUND_COUNT - 1);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/md5_round_ctl_if.sv
// ---------------------------------------------------------------------------
// md5_round_ctl_if
// Bundles the message-word stream, the abort control and the round-datapath
// handshake of the MD5 round sequencer.
//   clear_i   : synchronous abort of any partial or in-flight block
//   wvalid_i  : message word valid
//   wdata_i   : message word (word 0 first, little-endian word order)
//   wready_o  : sequencer can accept a word
//   stall_i   : datapath back-pressure, holds the current round
//   step_o    : datapath performs round round_o this cycle
//   round_o   : current round index 0..63
//   m_o       : message word for round_o
//   first_o   : round 0 in progress
//   last_o    : round 63 in progress
//   done_o    : one-cycle pulse after the final round
//   busy_o    : running or finishing a block
// modport slave is the sequencer; modport master is the source/datapath side.
// ---------------------------------------------------------------------------
interface md5_round_ctl_if;

    logic        clear_i;
    logic        wvalid_i;
    logic [31:0] wdata_i;
    logic        wready_o;
    logic        stall_i;
    logic        step_o;
    logic [5:0]  round_o;
    logic [31:0] m_o;
    logic        first_o;
    logic        last_o;
    logic        done_o;
    logic        busy_o;

    modport slave (
        input  clear_i,
        input  wvalid_i,
        input  wdata_i,
        input  stall_i,
        output wready_o,
        output step_o,
        output round_o,
        output m_o,
        output first_o,
        output last_o,
        output done_o,
        output busy_o
    );

    modport master (
        output clear_i,
        output wvalid_i,
        output wdata_i,
        output stall_i,
        input  wready_o,
        input  step_o,
        input  round_o,
        input  m_o,
        input  first_o,
        input  last_o,
        input  done_o,
        input  busy_o
    );

endinterface

// File: rtl/md5_round_ctl_ilut.sv
// ---------------------------------------------------------------------------
// md5_round_ctl_ilut
// MD5 message-index permutation: maps a round index to the buffer word used
// in that round.
//   round : round index 0..63
//   index : message word index 0..15
// Rounds 0-15 use i, 16-31 use (5i+1) mod 16, 32-47 use (3i+5) mod 16 and
// 48-63 use 7i mod 16. Because 16 divides every multiple of 16, only the low
// four bits of the round take part in the arithmetic, and the 4-bit result
// wraps modulo 16 by itself.
// ---------------------------------------------------------------------------
module md5_round_ctl_ilut (
    input  logic [5:0] round,
    output logic [3:0] index
);

    logic [3:0] low;

    assign low = round[3:0];

    always_comb begin
        index = low;
        unique case (round[5:4])
            2'd0: index = low;
            2'd1: index = 4'(low * 4'd5 + 4'd1);
            2'd2: index = 4'(low * 4'd3 + 4'd5);
            2'd3: index = 4'(low * 4'd7);
            default: index = low;
        endcase
    end

endmodule

// File: rtl/md5_round_ctl.sv
// ---------------------------------------------------------------------------
// md5_round_ctl
// Round sequencer for the MD5 core. Buffers sixteen 32-bit message words,
// then walks the datapath through rounds 0..63 presenting the round index and
// the permuted message word, and pulses done_o when the block is complete.
// Ports:
//   clk_i : core clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : md5_round_ctl_if.slave (word stream, abort, round handshake)
// Every output except step_o is decoded from registered state; step_o also
// depends on stall_i so a stalled round is never reported as performed.
// ---------------------------------------------------------------------------
module md5_round_ctl
    import md5_round_ctl_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    md5_round_ctl_if.slave  bus
);

    state_t      state_reg;
    state_t      state_next;
    logic [3:0]  wcnt_reg;
    logic [3:0]  wcnt_next;
    logic [5:0]  round_reg;
    logic [5:0]  round_next;

    logic        accept;
    logic [3:0]  msg_idx;
    logic [31:0] msg_buf [WORD_COUNT];

    // A word is taken only in LOAD; an abort in the same cycle drops it.
    assign accept = (state_reg == ST_LOAD) && bus.wvalid_i && !bus.clear_i;

    // Single message buffer. Contents are never reset: each word is always
    // rewritten before the rounds that read it.
    generate
        for (genvar gi = 0; gi < WORD_COUNT; gi++) begin : g_word
            always_ff @(posedge clk_i) begin
                if (accept && (wcnt_reg == 4'(gi))) begin
                    msg_buf[gi] <= bus.wdata_i;
                end
            end
        end
    endgenerate

    // State and counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= ST_LOAD;
            wcnt_reg  <= 4'd0;
            round_reg <= 6'd0;
        end else begin
            state_reg <= state_next;
            wcnt_reg  <= wcnt_next;
            round_reg <= round_next;
        end
    end

    // Next-state logic. The counters never rely on natural wrap-around; the
    // last word and last round are detected explicitly.
    always_comb begin
        state_next = state_reg;
        wcnt_next  = wcnt_reg;
        round_next = round_reg;

        if (bus.clear_i) begin
            state_next = ST_LOAD;
            wcnt_next  = 4'd0;
            round_next = 6'd0;
        end else begin
            unique case (state_reg)
                ST_LOAD: begin
                    if (bus.wvalid_i) begin
                        if (wcnt_reg == LAST_WORD) begin
                            wcnt_next  = 4'd0;
                            round_next = 6'd0;
                            state_next = ST_RUN;
                        end else begin
                            wcnt_next = wcnt_reg + 4'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (!bus.stall_i) begin
                        if (round_reg == LAST_ROUND) begin
                            state_next = ST_DONE;
                        end else begin
                            round_next = round_reg + 6'd1;
                        end
                    end
                end
                ST_DONE: begin
                    // Completion pulse lasts exactly one cycle; stall is ignored.
                    state_next = ST_LOAD;
                    round_next = 6'd0;
                end
                default: begin
                    state_next = ST_LOAD;
                    wcnt_next  = 4'd0;
                    round_next = 6'd0;
                end
            endcase
        end
    end

    md5_round_ctl_ilut u_ilut (
        .round (round_reg),
        .index (msg_idx)
    );

    // Output decode
    assign bus.wready_o = (state_reg == ST_LOAD);
    assign bus.step_o   = (state_reg == ST_RUN) && !bus.stall_i;
    assign bus.round_o  = round_reg;
    assign bus.m_o      = msg_buf[msg_idx];
    assign bus.first_o  = (state_reg == ST_RUN) && (round_reg == 6'd0);
    assign bus.last_o   = (state_reg == ST_RUN) && (round_reg == LAST_ROUND);
    assign bus.done_o   = (state_reg == ST_DONE);
    assign bus.busy_o   = (state_reg == ST_RUN) || (state_reg == ST_DONE);

endmodule

// File: doc/md5_round_ctl.md
# md5_round_ctl

Round sequencer for the MD5 core. It accepts one 512-bit message block as sixteen 32-bit words over a valid/ready stream and buffers them. It then steps the round datapath through rounds 0–63, presenting the round index and the message word selected for each round. It signals the first round, the last round and block completion, so the datapath can load and then add its chaining values.

## Interface
Parameters: none. Word count (16) and round count (64) come from the shared defines.

Ports:
- clk_i  in  1  core clock; all state changes on the rising edge
- rst_i  in  1  asynchronous, active-high reset
- clear_i  in  1  synchronous abort; drops any partial or in-flight block
- wvalid_i  in  1  message word valid
- wdata_i  in  32  message word; word 0 first, already in MD5 little-endian word order
- wready_o  out  1  word accepted on an edge where wvalid_i && wready_o
- stall_i  in  1  datapath back-pressure; holds the current round
- step_o  out  1  datapath performs round round_o this cycle
- round_o  out  6  current round index, 0–63
- m_o  out  32  message word for round_o; meaningful only while step_o = 1
- first_o  out  1  RUN state and round_o = 0 (datapath loads A–D from chaining)
- last_o  out  1  RUN state and round_o = 63
- done_o  out  1  one-cycle pulse after round 63 completes (datapath adds chaining)
- busy_o  out  1  state is RUN or DONE

## Operation
- FSM states: LOAD, RUN, DONE. Reset state is LOAD.
- LOAD:
  - wready_o = 1.
  - Each accepted word is written to buf[wcnt], then wcnt increments.
  - On acceptance of the word with wcnt = 15: wcnt returns to 0, round goes to 0, state goes to RUN.
  - Gaps in wvalid_i are allowed and change nothing.
- RUN:
  - wready_o = 0.
  - step_o = !stall_i.
  - m_o = buf[ilut(round_o)], using the standard MD5 message-index permutation.
  - On each edge with step_o = 1: if round = 63, go to DONE; otherwise round increments.
  - With stall_i = 1, round and all outputs hold.
- DONE:
  - done_o = 1 and step_o = 0 for one cycle, unconditionally; stall_i is ignored.
  - Next state is LOAD, with round = 0.
- Width rules: round is a 6-bit counter and wcnt is a 4-bit counter. Neither wraps on its own; transitions are decided explicitly at 63 and 15.
- clear_i, any state: next state is LOAD, wcnt = 0, round = 0, and no done_o pulse is produced.
  - clear_i wins over a simultaneous word acceptance; that word is dropped.
  - clear_i wins over step completion at round 63; DONE is not entered.
- Buffer contents are not reset and are don't-care outside valid use.
- rst_i asserted mid-block: the block returns immediately to reset values; the partial block is discarded.
- Reset values: wready_o = 1; step_o, first_o, last_o, done_o and busy_o = 0; round_o = 0. m_o is don't-care.

## Timing
- All outputs are decoded from registered state, round and buffer. There is no combinational path from wvalid_i, wdata_i or clear_i to any output.
  - Exception: step_o depends combinationally on stall_i.
- Load latency: the 16th accepted word at edge E puts RUN with round 0 in the cycle after E.
- Best-case block time is 81 cycles: 16 load + 64 run + 1 done.
  - Each stalled cycle adds one cycle.
- After DONE, wready_o returns the next cycle. There is no overlap of loading with running, because the buffer is single.

## Structure
- defines.h holds:
  - state encodings (LOAD = 0, RUN = 1, DONE = 2; 2-bit state)
  - word count 16
  - last round 63
- Sub-module: the existing ilut message-index lookup, instantiated once and driven by round_o. Its 4-bit output indexes the 16×32 buffer read mux.
- Everything else stays in one module: FSM, two counters, buffer, read mux.

## Test plan
- Reset: assert rst_i mid-cycle. Outputs immediately show wready_o = 1, round_o = 0, and all other status outputs = 0.
- Nominal block: load words buf[i] = 32'h1000_0000 + i on 16 consecutive cycles 0–15, with stall_i = 0.
  - first_o in cycle 16 with m_o = 0x10000000.
  - Round 16 gives m_o = 0x10000001; round 17 gives 0x10000006; round 63 (cycle 79) gives 0x10000009 with last_o = 1.
  - done_o in cycle 80; wready_o in cycle 81.
- Gapped load and stall:
  - wvalid_i toggles every other cycle; exactly 16 words are captured in order.
  - stall_i held for 3 cycles at round 40: round_o stays at 40, step_o = 0 and m_o stays at buf[13]; done_o arrives 3 cycles later than nominal.
- clear_i during RUN at round 30: LOAD follows, no done_o pulse occurs, and a fresh 16-word load runs correctly.
- clear_i together with the 10th word acceptance: that word is dropped; the next 16 words form the block, starting from buf[0].
- Back-to-back blocks: the second block's words are accepted only after DONE, and its m_o sequence reflects the new data only.
